seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//  Time-multiplexes one shared 7-segment bus across DIGITS common-anode digits.
//  Holds a hex value per digit, scans digits round-robin with a blanking gap
//  between them to prevent ghosting, and accepts new display words via a
//  valid/ready handshake. Updates land only at frame start, so frames never tear.
//  Sits between counter/datapath logic and the board display pins.
// PARAMETERS
//  DIGITS     4      number of digits scanned (2..8)
//  SCAN_DIV   50000  clk cycles each digit is lit (>=2)
//  BLANK_CYC  16     clk cycles all digits dark between digits (>=1)
// PORTS
//  clk         in   1           system clock, rising edge
//  rst_n       in   1           asynchronous active-low reset
//  enable      in   1           1 = scan; 0 = display dark, scan index held at 0
//  lz_en       in   1           1 = suppress leading zeros (digit 0 always shown)
//  upd_valid   in   1           new display word offered
//  upd_data    in   4*DIGITS    nibble i = hex value of digit i (digit 0 = LSB)
//  upd_ready   out  1           word can be captured this cycle
//  seg         out  7           segments {a,b,c,d,e,f,g}, active-low
//  dig_n       out  DIGITS      digit enables, active-low, at most one low
//  frame_tick  out  1           1-cycle pulse when digit 0 starts its lit phase
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, idx=0, active/shadow words=0, pending=0;
//   seg=7'h7F, dig_n=all 1s, frame_tick=0, upd_ready=1.
//  FSM (one counter cnt, width $clog2(max(SCAN_DIV,BLANK_CYC))):
//   IDLE : dark. If pending, commit shadow->active next cycle. enable=1 -> BLANK, idx=0, cnt=0.
//   BLANK: dark for BLANK_CYC cycles -> SHOW with the same idx.
//   SHOW : dig_n[idx]=0, seg=~glyph(active[idx]) for SCAN_DIV cycles -> BLANK,
//          idx=idx+1, wrapping DIGITS-1 -> 0.
//   enable=0 in any state -> IDLE on next edge, outputs dark on that same edge, idx=0.
//  Outputs are registered and change on the same edge as the state transition.
//   No combinational path from inputs to outputs.
//  Handshake: upd_ready = ~pending. Capture on upd_valid & upd_ready into shadow,
//   set pending. upd_data may change freely while upd_ready=0.
//  Commit: on the BLANK->SHOW edge with idx=0, if pending then active<=shadow,
//   pending<=0. frame_tick pulses on that same edge. A digit shown during frame
//   k therefore uses data committed at the start of frame k.
//  Capture and commit can never occur in the same cycle: capture needs
//   pending=0 and commit needs pending=1.
//  Leading zeros: with lz_en=1, digit i>0 is dark (dig_n stays 1 for its lit
//   slot; timing unchanged) if active[i..DIGITS-1] are all 0.
//  Glyph table (active-high abcdefg): 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70
//   8=7F 9=7B A=77 b=1F C=4E d=3D E=4F F=47. seg = ~glyph.
//  Frame period = DIGITS*(SCAN_DIV+BLANK_CYC) cycles.
// STRUCTURE
//  Package seg_pkg: 16-entry glyph constant table, state enum {IDLE,BLANK,SHOW}.
//   The package is shared with the other display blocks.
//  Sub-module hex7seg: combinational nibble -> active-low 7-bit seg,
//   instantiated once on the muxed nibble.
// TESTING (bench: DIGITS=4, SCAN_DIV=8, BLANK_CYC=2)
//  1 Reset mid-SHOW, with rst_n low for 1 cycle -> seg=7F and dig_n=F immediately
//    (async); upd_ready=1.
//  2 upd_data=16'h1234, enable=1 -> frame_tick at cycle 3. Digits lit in order:
//    dig_n E/seg 4C(4), D/06(3), B/12(2), 7/4F(1). Each lit 8 cycles with
//    2 dark cycles between.
//  3 Second word 16'hABCD offered mid-frame -> upd_ready=0 until the next frame
//    start. New digits appear only from the next frame_tick; no mixed frame.
//  4 lz_en=1, word 16'h0005 -> only digit 0 lit (seg 24). The slots for
//    digits 1-3 stay dark with unchanged timing. Word 0000 -> digit 0 shows 01.
//  5 enable dropped during SHOW of digit 2 -> dark on next edge. Re-enable ->
//    restarts at digit 0 after 2 blank cycles.
//  6 upd_valid held high continuously -> exactly one capture per frame;
//    frame period stays 40 cycles.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: glyph table and scan states shared by the display blocks.
package seg_pkg;
    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
    localparam logic [6:0] GLYPH [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };
endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: valid/ready update channel carrying one display word.
interface seg_scan_ctrl_if #(parameter int DIGITS = 4);
    logic                  upd_valid;
    logic [4*DIGITS-1:0]   upd_data;
    logic                  upd_ready;
    modport master (output upd_valid, upd_data, input upd_ready);
    modport slave  (input upd_valid, upd_data, output upd_ready);
endinterface

// File: rtl/hex7seg.sv
// hex7seg: nibble to active-low {a..g} segment pattern.
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    assign seg = ~GLYPH[nib];
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: round-robin 7-segment scanner with blanking gaps and
// frame-aligned word updates.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              lz_en,
    seg_scan_ctrl_if.slave    upd,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] dig_n,
    output logic              frame_tick
);
    localparam int CW = $clog2(SCAN_DIV > BLANK_CYC ? SCAN_DIV : BLANK_CYC);
    localparam int IW = $clog2(DIGITS);

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] active, shadow, word_nxt;
    logic                pending, commit, blank_end, show_end, lz_dark;
    logic [3:0]          nib;
    logic [6:0]          glyph_seg;

    assign upd.upd_ready = ~pending;
    assign blank_end = state == BLANK && cnt == CW'(BLANK_CYC - 1);
    assign show_end  = state == SHOW && cnt == CW'(SCAN_DIV - 1);
    assign commit    = pending && (state == IDLE || (enable && blank_end && idx == '0));
    // Digit glyph is latched on the commit edge itself, so look through to the new word
    assign word_nxt  = commit ? shadow : active;
    assign nib       = word_nxt[{idx, 2'b00} +: 4];
    assign lz_dark   = lz_en && idx != '0 && (word_nxt >> {idx, 2'b00}) == '0;

    hex7seg u_hex (.nib(nib), .seg(glyph_seg));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            active     <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            seg        <= 7'h7F;
            dig_n      <= '1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            if (upd.upd_valid && !pending) begin
                shadow  <= upd.upd_data;
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
            if (commit)
                active <= shadow;
            if (!enable) begin
                state <= IDLE;
                idx   <= '0;
                cnt   <= '0;
                seg   <= 7'h7F;
                dig_n <= '1;
            end else begin
                case (state)
                    IDLE: begin
                        state <= BLANK;
                        idx   <= '0;
                        cnt   <= '0;
                    end
                    BLANK: begin
                        cnt <= blank_end ? '0 : cnt + 1'b1;
                        if (blank_end) begin
                            state      <= SHOW;
                            frame_tick <= idx == '0;
                            seg        <= lz_dark ? 7'h7F : glyph_seg;
                            dig_n      <= lz_dark ? '1 : ~(DIGITS'(1) << idx);
                        end
                    end
                    SHOW: begin
                        cnt <= show_end ? '0 : cnt + 1'b1;
                        if (show_end) begin
                            state <= BLANK;
                            idx   <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
                            seg   <= 7'h7F;
                            dig_n <= '1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed checks of scan timing, update handshake,
// leading-zero blanking, enable drop and async reset.
module tb_seg_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst_n, enable, lz_en;
    logic [6:0] seg;
    logic [3:0] dig_n;
    logic       frame_tick;
    int         n_cmp = 0;
    int         n_bad = 0;

    seg_scan_ctrl_if #(.DIGITS(4)) upd_if ();

    seg_scan_ctrl #(.DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .lz_en(lz_en), .upd(upd_if),
        .seg(seg), .dig_n(dig_n), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered at the first lit sample of digit 0; leaves at the next frame's first lit sample.
    // mode 0: no offer; 1: pulse word at digit 1; 2: hold valid, word only on the first cycle.
    task automatic frame_chk(input string tag, input logic [15:0] dexp, input logic [27:0] sexp,
                             input int mode, input logic [15:0] word);
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 10; c++) begin
                chk({tag, "_dig"}, 32'(dig_n), (c < 8) ? 32'(dexp[d*4 +: 4]) : 32'hF);
                chk({tag, "_seg"}, 32'(seg), (c < 8) ? 32'(sexp[d*7 +: 7]) : 32'h7F);
                chk({tag, "_tick"}, 32'(frame_tick), 32'(d == 0 && c == 0));
                if (d == 3 && c == 9)
                    chk({tag, "_rdy_end"}, 32'(upd_if.upd_ready), 32'(mode == 0));
                if (mode == 0 && d == 0 && c == 0)
                    upd_if.upd_valid = 1'b0;
                if ((mode == 1 && d == 1 && c == 0) || (mode == 2 && d == 0 && c == 0)) begin
                    upd_if.upd_valid = 1'b1;
                    upd_if.upd_data  = word;
                end
                tick();
                if (mode == 1 && d == 1 && c == 0) begin
                    upd_if.upd_valid = 1'b0;
                    upd_if.upd_data  = 16'hFFFF;
                    chk({tag, "_rdy_lo"}, 32'(upd_if.upd_ready), 32'h0);
                end
                if (mode == 2 && d == 0 && c == 0) begin
                    upd_if.upd_data = ~word;
                    chk({tag, "_rdy_lo"}, 32'(upd_if.upd_ready), 32'h0);
                end
            end
        end
    endtask

    localparam logic [15:0] D4   = 16'h7BDE;
    localparam logic [15:0] D1   = 16'hFFFE;
    localparam logic [27:0] S1234 = {7'h4F, 7'h12, 7'h06, 7'h4C};
    localparam logic [27:0] SABCD = {7'h08, 7'h60, 7'h31, 7'h42};
    localparam logic [27:0] S5LZ  = {7'h7F, 7'h7F, 7'h7F, 7'h24};
    localparam logic [27:0] S0LZ  = {7'h7F, 7'h7F, 7'h7F, 7'h01};
    localparam logic [27:0] S0000 = {7'h01, 7'h01, 7'h01, 7'h01};

    initial begin
        rst_n = 1'b0; enable = 1'b0; lz_en = 1'b0;
        upd_if.upd_valid = 1'b0; upd_if.upd_data = '0;
        tick(); tick();
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dig", 32'(dig_n), 32'hF);
        chk("rst_tick", 32'(frame_tick), 32'h0);
        chk("rst_rdy", 32'(upd_if.upd_ready), 32'h1);
        rst_n = 1'b1;
        tick();
        upd_if.upd_data = 16'h1234; upd_if.upd_valid = 1'b1; enable = 1'b1;
        tick();
        upd_if.upd_valid = 1'b0;
        chk("start_rdy", 32'(upd_if.upd_ready), 32'h0);
        chk("start_dig1", 32'(dig_n), 32'hF);
        tick();
        chk("start_dig2", 32'(dig_n), 32'hF);
        chk("start_tick2", 32'(frame_tick), 32'h0);
        tick();
        chk("start_rdy3", 32'(upd_if.upd_ready), 32'h1);
        frame_chk("f1234", D4, S1234, 1, 16'hABCD);
        chk("commit_rdy", 32'(upd_if.upd_ready), 32'h1);
        lz_en = 1'b1;
        frame_chk("fabcd", D4, SABCD, 1, 16'h0005);
        frame_chk("f0005lz", D1, S5LZ, 1, 16'h0000);
        frame_chk("f0000lz", D1, S0LZ, 0, 16'h0000);
        lz_en = 1'b0;
        frame_chk("hold0", D4, S0000, 2, 16'h1234);
        frame_chk("hold1", D4, S1234, 2, 16'hABCD);
        frame_chk("hold2", D4, SABCD, 0, 16'h0000);
        repeat (20) tick();
        chk("en_d2_dig", 32'(dig_n), 32'hB);
        chk("en_d2_seg", 32'(seg), 32'h60);
        repeat (3) tick();
        enable = 1'b0;
        tick();
        chk("en_off_dig", 32'(dig_n), 32'hF);
        chk("en_off_seg", 32'(seg), 32'h7F);
        repeat (3) tick();
        chk("en_idle_dig", 32'(dig_n), 32'hF);
        enable = 1'b1;
        tick();
        chk("re_b1_dig", 32'(dig_n), 32'hF);
        tick();
        chk("re_b2_dig", 32'(dig_n), 32'hF);
        chk("re_b2_tick", 32'(frame_tick), 32'h0);
        tick();
        frame_chk("fre", D4, SABCD, 0, 16'h0000);
        repeat (3) tick();
        #3 rst_n = 1'b0;
        #1;
        chk("arst_seg", 32'(seg), 32'h7F);
        chk("arst_dig", 32'(dig_n), 32'hF);
        chk("arst_rdy", 32'(upd_if.upd_ready), 32'h1);
        chk("arst_tick", 32'(frame_tick), 32'h0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post_tick", 32'(frame_tick), 32'h1);
        chk("post_dig", 32'(dig_n), 32'hE);
        chk("post_seg", 32'(seg), 32'h01);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
